// File: rtl/axi4_lite_master.sv
// -----------------------------------------------------------------------------
// axi4_lite_master
//
// AXI4-Lite initiator. Takes single-beat commands from a valid/ready command
// port, runs them as one AXI4-Lite read or write transaction on the M_* bus,
// and hands the read data and response code back on a valid/ready response
// port. Only one transaction is in flight at a time.
//
// Ports
//   ACLK, ARESETN           clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_write               1 = write, 0 = read
//   cmd_addr                byte address, forwarded unmodified
//   cmd_wdata/cmd_wstrb     write data and byte strobes
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata               read data (0 for writes)
//   rsp_resp                BRESP or RRESP of the completed transaction
//   rsp_write               echo of cmd_write for the completed transaction
//   M_AW*, M_W*, M_B*       AXI4-Lite write address / data / response channels
//   M_AR*, M_R*             AXI4-Lite read address / data channels
//
// Every output comes straight from a flop; no input reaches an output
// combinationally. DATA_WIDTH is expected to be 32 or 64.
// -----------------------------------------------------------------------------
module axi4_lite_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,

    // command port
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,

    // response port
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic                      rsp_write,

    // write address channel
    output logic [ADDR_WIDTH-1:0]     M_AWADDR,
    output logic                      M_AWVALID,
    input  logic                      M_AWREADY,

    // write data channel
    output logic [DATA_WIDTH-1:0]     M_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_WSTRB,
    output logic                      M_WVALID,
    input  logic                      M_WREADY,

    // write response channel
    input  logic [1:0]                M_BRESP,
    input  logic                      M_BVALID,
    output logic                      M_BREADY,

    // read address channel
    output logic [ADDR_WIDTH-1:0]     M_ARADDR,
    output logic                      M_ARVALID,
    input  logic                      M_ARREADY,

    // read data channel
    input  logic [DATA_WIDTH-1:0]     M_RDATA,
    input  logic [1:0]                M_RRESP,
    input  logic                      M_RVALID,
    output logic                      M_RREADY
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t                  state_q,     state_d;
    logic                    cmd_ready_q, cmd_ready_d;

    logic [ADDR_WIDTH-1:0]   awaddr_q,    awaddr_d;
    logic                    awvalid_q,   awvalid_d;
    logic [DATA_WIDTH-1:0]   wdata_q,     wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q,     wstrb_d;
    logic                    wvalid_q,    wvalid_d;
    logic                    aw_done_q,   aw_done_d;
    logic                    w_done_q,    w_done_d;
    logic                    bready_q,    bready_d;

    logic [ADDR_WIDTH-1:0]   araddr_q,    araddr_d;
    logic                    arvalid_q,   arvalid_d;
    logic                    rready_q,    rready_d;

    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q,  rsp_resp_d;
    logic                    rsp_write_q, rsp_write_d;

    // Handshake qualifiers, built from the registered VALID/READY we drive.
    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;

    assign aw_hs = awvalid_q & M_AWREADY;
    assign w_hs  = wvalid_q  & M_WREADY;
    assign b_hs  = bready_q  & M_BVALID;
    assign ar_hs = arvalid_q & M_ARREADY;
    assign r_hs  = rready_q  & M_RVALID;

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        awaddr_d    = awaddr_q;
        awvalid_d   = awvalid_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        wvalid_d    = wvalid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bready_d    = bready_q;
        araddr_d    = araddr_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        rsp_write_d = rsp_write_q;

        case (state_q)
            IDLE: begin
                // cmd_ready is low straight out of reset and comes up on the
                // first edge after release, so acceptance uses the registered
                // copy rather than the state.
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        aw_done_d = 1'b0;
                        w_done_d  = 1'b0;
                        state_d   = WR;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end

            WR: begin
                // AW and W run independently; each VALID falls only on the
                // edge that samples its own READY.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // Include this cycle's handshakes so a simultaneous or
                // last-arriving handshake moves on without an idle cycle.
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end

            WR_RESP: begin
                if (b_hs) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = M_BRESP;
                    rsp_rdata_d = '0;
                    rsp_write_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end

            RD_ADDR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end

            RD_DATA: begin
                if (r_hs) begin
                    rready_d    = 1'b0;
                    rsp_rdata_d = M_RDATA;
                    rsp_resp_d  = M_RRESP;
                    rsp_write_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end

            RSP: begin
                // rsp_* hold their values until the requester takes them.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b0;
                awvalid_d   = 1'b0;
                wvalid_d    = 1'b0;
                bready_d    = 1'b0;
                arvalid_d   = 1'b0;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            awaddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            rsp_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awaddr_q    <= awaddr_d;
            awvalid_q   <= awvalid_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wvalid_q    <= wvalid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            bready_q    <= bready_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_write_q <= rsp_write_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cmd_ready = cmd_ready_q;

    assign M_AWADDR  = awaddr_q;
    assign M_AWVALID = awvalid_q;
    assign M_WDATA   = wdata_q;
    assign M_WSTRB   = wstrb_q;
    assign M_WVALID  = wvalid_q;
    assign M_BREADY  = bready_q;
    assign M_ARADDR  = araddr_q;
    assign M_ARVALID = arvalid_q;
    assign M_RREADY  = rready_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign rsp_write = rsp_write_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_master
//
// Bench for axi4_lite_master. A small AXI4-Lite memory slave with
// configurable or random wait states answers the bus. Every accepted command
// is run through a word-array reference model and the expected response is
// queued; a monitor pops and compares on each response handshake and also
// checks channel stability, BREADY ordering, cmd_ready gating and latency.
// Address region 0xF00-0xFFF answers with SLVERR (bit 2 clear) or DECERR
// (bit 2 set), read data 0x12345678, and ignores writes.
// -----------------------------------------------------------------------------
module tb_axi4_lite_master;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b1;

    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
    logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY;
    logic [3:0]  M_WSTRB;
    logic [1:0]  M_BRESP, M_RRESP;
    logic        M_BVALID, M_BREADY, M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;

    always #5 ACLK = ~ACLK;

    axi4_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_write(rsp_write),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rsp_count = 0;
    int          accept_cyc = 0;
    logic        check_lat = 1'b0;
    logic        rand_mode = 1'b0;
    int          aw_dly_cfg = 0, w_dly_cfg = 0, ar_dly_cfg = 0;
    int          b_dly_cfg = 0, r_dly_cfg = 0, rsp_dly_cfg = 0;
    logic [31:0] mmem [256];
    logic [31:0] smem [256];
    logic [31:0] last_rdata = '0;
    logic [1:0]  last_resp = '0;
    logic        last_write = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [1:0] region_resp(input logic [31:0] a);
        if (a[11:8] == 4'hF) return a[2] ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    // Reference model: a plain word array updated with a byte mask.
    function automatic exp_t model_txn(input logic w, input logic [31:0] a,
                                       input logic [31:0] d, input logic [3:0] s);
        exp_t        e;
        logic [31:0] mask;
        e.write = w;
        e.addr  = a;
        e.resp  = region_resp(a);
        e.rdata = '0;
        if (w) begin
            mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
            if (e.resp == 2'b00) mmem[a[9:2]] = (mmem[a[9:2]] & ~mask) | (d & mask);
        end else begin
            e.rdata = (e.resp != 2'b00) ? 32'h12345678 : mmem[a[9:2]];
        end
        return e;
    endfunction

    initial begin
        forever begin
            @(posedge ACLK);
            cyc++;
        end
    end

    // -------------------------------------------------------------------------
    // Slave model: outputs change 1 time unit after the rising edge, based on
    // handshakes sampled at the preceding falling edge.
    // -------------------------------------------------------------------------
    initial begin
        logic        hs_aw, hs_w, hs_b, hs_ar, hs_r;
        logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
        logic [3:0]  cap_wstrb;
        logic        aw_got, w_got, b_pend, r_pend;
        logic [31:0] s_addr, s_data;
        logic [3:0]  s_strb;
        logic [1:0]  s_bresp;
        int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
        int          aw_dly, w_dly, ar_dly;
        M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_BRESP = 0;
        M_ARREADY = 0; M_RVALID = 0; M_RDATA = 0; M_RRESP = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        s_addr = 0; s_data = 0; s_strb = 0; s_bresp = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_dly = 0; w_dly = 0; ar_dly = 0;
        forever begin
            @(negedge ACLK);
            hs_aw = M_AWVALID && M_AWREADY;
            hs_w  = M_WVALID && M_WREADY;
            hs_b  = M_BVALID && M_BREADY;
            hs_ar = M_ARVALID && M_ARREADY;
            hs_r  = M_RVALID && M_RREADY;
            cap_awaddr = M_AWADDR; cap_wdata = M_WDATA;
            cap_wstrb  = M_WSTRB;  cap_araddr = M_ARADDR;
            @(posedge ACLK);
            #1;
            if (!ARESETN) begin
                M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_BRESP = 0;
                M_ARREADY = 0; M_RVALID = 0; M_RDATA = 0; M_RRESP = 0;
                aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            end else begin
                // READY after a programmable number of cycles of VALID.
                if (!M_AWVALID) begin
                    aw_cnt = 0;
                    aw_dly = rand_mode ? int'($urandom_range(0, 3)) : aw_dly_cfg;
                end
                M_AWREADY = (aw_cnt >= aw_dly);
                if (M_AWVALID) aw_cnt++;
                if (!M_WVALID) begin
                    w_cnt = 0;
                    w_dly = rand_mode ? int'($urandom_range(0, 3)) : w_dly_cfg;
                end
                M_WREADY = (w_cnt >= w_dly);
                if (M_WVALID) w_cnt++;
                if (!M_ARVALID) begin
                    ar_cnt = 0;
                    ar_dly = rand_mode ? int'($urandom_range(0, 3)) : ar_dly_cfg;
                end
                M_ARREADY = (ar_cnt >= ar_dly);
                if (M_ARVALID) ar_cnt++;

                // write path
                if (hs_b) M_BVALID = 0;
                if (hs_aw) begin aw_got = 1; s_addr = cap_awaddr; end
                if (hs_w)  begin w_got = 1; s_data = cap_wdata; s_strb = cap_wstrb; end
                if (aw_got && w_got) begin
                    aw_got  = 0;
                    w_got   = 0;
                    s_bresp = region_resp(s_addr);
                    if (s_bresp == 2'b00) begin
                        for (int b = 0; b < 4; b++)
                            if (s_strb[b]) smem[s_addr[9:2]][8*b +: 8] = s_data[8*b +: 8];
                    end
                    b_pend = 1;
                    b_cnt  = rand_mode ? int'($urandom_range(0, 4)) : b_dly_cfg;
                end
                if (b_pend) begin
                    if (b_cnt == 0) begin
                        M_BVALID = 1; M_BRESP = s_bresp; b_pend = 0;
                    end else begin
                        b_cnt--;
                    end
                end

                // read path
                if (hs_r) M_RVALID = 0;
                if (hs_ar) begin
                    r_pend  = 1;
                    r_cnt   = rand_mode ? int'($urandom_range(0, 4)) : r_dly_cfg;
                    M_RRESP = region_resp(cap_araddr);
                    M_RDATA = (M_RRESP != 2'b00) ? 32'h12345678 : smem[cap_araddr[9:2]];
                end
                if (r_pend) begin
                    if (r_cnt == 0) begin
                        M_RVALID = 1; r_pend = 0;
                    end else begin
                        r_cnt--;
                    end
                end
            end
        end
    end

    // Requester side of the response port.
    initial begin
        int rcnt, rdly;
        rsp_ready = 0; rcnt = 0; rdly = 0;
        forever begin
            @(posedge ACLK);
            #1;
            if (!ARESETN) begin
                rsp_ready = 0; rcnt = 0;
            end else begin
                if (!rsp_valid) begin
                    rcnt = 0;
                    rdly = rand_mode ? int'($urandom_range(0, 3)) : rsp_dly_cfg;
                end
                rsp_ready = (rcnt >= rdly);
                if (rsp_valid) rcnt++;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Monitor / scoreboard, sampling on the falling edge.
    // -------------------------------------------------------------------------
    initial begin
        logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rv, p_rr;
        logic [31:0] p_awaddr, p_wdata, p_araddr, p_rdata;
        logic [3:0]  p_wstrb;
        logic [1:0]  p_resp;
        logic        p_rwrite;
        exp_t        e;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; p_rv = 0; p_rr = 0;
        p_awaddr = 0; p_wdata = 0; p_araddr = 0; p_rdata = 0; p_wstrb = 0; p_resp = 0; p_rwrite = 0;
        forever begin
            @(negedge ACLK);
            if (ARESETN) begin
                if (p_awv && !p_awr) chk("aw_hold", 64'({M_AWVALID, M_AWADDR}), 64'({1'b1, p_awaddr}));
                if (p_awv && p_awr)  chk("aw_drop", 64'(M_AWVALID), 64'(0));
                if (p_wv && !p_wr)   chk("w_hold", 64'({M_WVALID, M_WSTRB, M_WDATA}), 64'({1'b1, p_wstrb, p_wdata}));
                if (p_wv && p_wr)    chk("w_drop", 64'(M_WVALID), 64'(0));
                if (p_arv && !p_arr) chk("ar_hold", 64'({M_ARVALID, M_ARADDR}), 64'({1'b1, p_araddr}));
                if (p_arv && p_arr)  chk("ar_drop", 64'(M_ARVALID), 64'(0));
                if (M_BREADY)        chk("bready_after_aw_w", 64'({M_AWVALID, M_WVALID}), 64'(0));
                if (p_rv && !p_rr)
                    chk("rsp_hold", 64'({rsp_valid, rsp_write, rsp_resp, rsp_rdata}),
                        64'({1'b1, p_rwrite, p_resp, p_rdata}));
                if (cmd_ready)       chk("cmd_ready_when_busy", 64'(sb.size()), 64'(0));
                if (check_lat && rsp_valid && !p_rv)
                    chk("rsp_latency", 64'(cyc - accept_cyc), 64'(3));

                if (cmd_valid && cmd_ready) begin
                    sb.push_back(model_txn(cmd_write, cmd_addr, cmd_wdata, cmd_wstrb));
                    accept_cyc = cyc;
                end

                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", 64'(1), 64'(0));
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_write", 64'(rsp_write), 64'(e.write));
                        chk("rsp_resp",  64'(rsp_resp),  64'(e.resp));
                        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                        $display("rsp %0d: %s addr=%h resp=%0d rdata=%h", rsp_count,
                                 e.write ? "WR" : "RD", e.addr, rsp_resp, rsp_rdata);
                    end
                    last_rdata = rsp_rdata;
                    last_resp  = rsp_resp;
                    last_write = rsp_write;
                    rsp_count++;
                end

                p_awv = M_AWVALID; p_awr = M_AWREADY; p_awaddr = M_AWADDR;
                p_wv = M_WVALID; p_wr = M_WREADY; p_wdata = M_WDATA; p_wstrb = M_WSTRB;
                p_arv = M_ARVALID; p_arr = M_ARREADY; p_araddr = M_ARADDR;
                p_rv = rsp_valid; p_rr = rsp_ready; p_rdata = rsp_rdata;
                p_resp = rsp_resp; p_rwrite = rsp_write;
            end else begin
                p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; p_rv = 0; p_rr = 0;
            end
        end
    end

    // Issue one command and wait for its response. Called 1 time unit after a
    // rising edge; returns 1 time unit after the response handshake edge.
    task automatic do_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int  n0;
        bit  ok;
        n0 = rsp_count;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge ACLK);
            if (cmd_ready) begin ok = 1; break; end
        end
        if (!ok) chk("cmd_accept_timeout", 64'(0), 64'(1));
        @(posedge ACLK);
        #1;
        cmd_valid = 0;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (rsp_count > n0) begin ok = 1; break; end
            @(posedge ACLK);
        end
        if (!ok) chk("rsp_timeout", 64'(0), 64'(1));
        #1;
    endtask

    initial begin
        logic [31:0] ra;
        int          sel;
        bit          ok;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        for (int i = 0; i < 256; i++) begin mmem[i] = '0; smem[i] = '0; end

        // reset state
        #2 ARESETN = 0;
        #1;
        chk("reset_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("reset_valids", 64'({M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid, rsp_write}), 64'(0));
        chk("reset_buses", 64'({M_AWADDR, M_ARADDR} | {M_WDATA, rsp_rdata}), 64'(0));
        chk("reset_strb_resp", 64'({M_WSTRB, rsp_resp}), 64'(0));
        repeat (3) @(posedge ACLK);
        #1;
        chk("reset_held_cmd_ready", 64'(cmd_ready), 64'(0));
        @(negedge ACLK);
        #1 ARESETN = 1;
        @(posedge ACLK);
        #1;
        chk("post_reset_cmd_ready", 64'(cmd_ready), 64'(1));

        // zero-wait write then read, with latency checking
        check_lat = 1;
        do_cmd(1, 32'h4, 32'hDEADBEEF, 4'hF);
        chk("zw_write_resp", 64'({last_write, last_resp, last_rdata}), 64'({1'b1, 2'b00, 32'h0}));
        do_cmd(0, 32'h4, 32'h0, 4'h0);
        chk("zw_read_data", 64'({last_write, last_resp, last_rdata}), 64'({1'b0, 2'b00, 32'hDEADBEEF}));
        check_lat = 0;

        // skewed write channels, both orders
        aw_dly_cfg = 4; w_dly_cfg = 1;
        do_cmd(1, 32'h10, 32'h11223344, 4'hF);
        aw_dly_cfg = 1; w_dly_cfg = 4;
        do_cmd(1, 32'h14, 32'h55667788, 4'b0101);
        aw_dly_cfg = 0; w_dly_cfg = 0;
        do_cmd(0, 32'h10, 32'h0, 4'h0);
        chk("skew1_data", 64'(last_rdata), 64'(32'h11223344));
        do_cmd(0, 32'h14, 32'h0, 4'h0);
        chk("skew2_strb_data", 64'(last_rdata), 64'(32'h00660088));

        // backpressure on B, R and the response port
        b_dly_cfg = 5; r_dly_cfg = 3; rsp_dly_cfg = 4;
        do_cmd(1, 32'h18, 32'hCAFEF00D, 4'hF);
        do_cmd(0, 32'h18, 32'h0, 4'h0);
        chk("bp_read_data", 64'(last_rdata), 64'(32'hCAFEF00D));
        b_dly_cfg = 0; r_dly_cfg = 0; rsp_dly_cfg = 0;

        // error passthrough, then a normal command
        do_cmd(0, 32'hFF0, 32'h0, 4'h0);
        chk("slverr_read", 64'({last_resp, last_rdata}), 64'({2'b10, 32'h12345678}));
        do_cmd(1, 32'h1C, 32'h0BADF00D, 4'hF);
        chk("after_err_write", 64'({last_write, last_resp}), 64'({1'b1, 2'b00}));

        // reset while M_ARVALID is high
        ar_dly_cfg = 50;
        cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h4;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (cmd_ready) begin ok = 1; break; end
        end
        if (!ok) chk("rst_cmd_accept_timeout", 64'(0), 64'(1));
        @(posedge ACLK);
        #1;
        cmd_valid = 0;
        @(negedge ACLK);
        chk("pre_reset_arvalid", 64'(M_ARVALID), 64'(1));
        #2 ARESETN = 0;
        #1;
        chk("async_reset_drop", 64'({M_ARVALID, cmd_ready}), 64'(0));
        sb.delete();
        ar_dly_cfg = 0;
        repeat (2) @(negedge ACLK);
        #1 ARESETN = 1;
        @(posedge ACLK);
        #1;
        chk("rst_release_cmd_ready", 64'(cmd_ready), 64'(1));
        do_cmd(1, 32'h8, 32'hA5A5A5A5, 4'hF);
        chk("post_rst_write", 64'({last_write, last_resp}), 64'({1'b1, 2'b00}));
        do_cmd(0, 32'h8, 32'h0, 4'h0);
        chk("post_rst_read", 64'(last_rdata), 64'(32'hA5A5A5A5));

        // random traffic against a random-wait slave
        rand_mode = 1;
        for (int t = 0; t < 200; t++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      ra = 32'hFF0;
            else if (sel == 1) ra = 32'hFF4;
            else               ra = 32'($urandom_range(0, 15)) << 2;
            do_cmd(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)));
        end
        rand_mode = 0;

        repeat (4) @(posedge ACLK);
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
